// File: rtl/led_frame_controller_if.sv
// Write port bundle for led_frame_controller.
// The host side (master) presents one LED word per cycle. The controller side
// (slave) reports through wr_ready whether that word is accepted on the edge.
//   wr_en    : host requests a shadow-buffer write this cycle
//   wr_addr  : LED index, 0 is the first LED on the wire
//   wr_data  : GRB word, [23:16] G, [15:8] R, [7:0] B
//   wr_ready : controller accepts the write this cycle
interface led_frame_controller_if #(
    parameter int NUM_LEDS = 64
);
    localparam int ADDR_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [23:0]       wr_data;
    logic              wr_ready;

    modport master (
        output wr_en,
        output wr_addr,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        output wr_ready
    );
endinterface

// File: rtl/led_frame_controller.sv
// Double-buffered frame store for an addressable LED chain.
// The host writes GRB words into a shadow buffer at any time except during a
// copy. A commit arms a publish. The next frame_gap from the serializer then
// starts a copy of one LED per cycle into the active buffer, scaling every
// channel by the brightness captured at the start of that copy. The serializer
// only ever sees the active buffer, so a frame it is shifting out is never torn.
// Ports:
//   clk, reset   : rising-edge clock, asynchronous active-high reset
//   wr           : write bus (wr_en, wr_addr, wr_data, wr_ready), slave side
//   brightness   : global scale, sampled when a copy starts
//   commit       : one-cycle request to publish the shadow buffer
//   frame_gap    : one-cycle pulse when the serializer enters its latch gap
//   busy         : high whenever the FSM is not IDLE
//   bits         : frame vector, LED 0 at the MSB end, G channel first
//   frame_count  : number of completed publishes, wraps at 16 bits
module led_frame_controller #(
    parameter int NUM_LEDS     = 64,
    parameter int BITS_PER_LED = 24
) (
    input  logic                             clk,
    input  logic                             reset,
    led_frame_controller_if.slave            wr,
    input  logic [7:0]                       brightness,
    input  logic                             commit,
    input  logic                             frame_gap,
    output logic                             busy,
    output logic [NUM_LEDS*BITS_PER_LED-1:0] bits,
    output logic [15:0]                      frame_count
);
    localparam int ADDR_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_LEDS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        COPY    = 2'd2
    } state_t;

    state_t            state;
    state_t            state_d;
    logic              start_copy;
    logic              copy_last;
    logic              wr_accept;
    logic [ADDR_W-1:0] idx;
    logic [7:0]        brt_q;
    logic              recommit;

    logic [23:0] shadow [NUM_LEDS];
    logic [23:0] active [NUM_LEDS];

    // (c * (b + 1)) >> 8 in 16 bits: b = 255 passes c through unchanged, and
    // b = 0 always gives 0 because 255 * 1 stays below 256.
    function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] b);
        logic [15:0] prod;
        prod = 16'(c) * (16'(b) + 16'd1);
        return prod[15:8];
    endfunction

    function automatic logic [23:0] scale_grb(input logic [23:0] grb, input logic [7:0] b);
        return {scale(grb[23:16], b), scale(grb[15:8], b), scale(grb[7:0], b)};
    endfunction

    assign busy        = (state != IDLE);
    assign wr.wr_ready = (state != COPY);
    assign wr_accept   = wr.wr_en && wr.wr_ready && (int'(wr.wr_addr) < NUM_LEDS);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // commit is ignored in PENDING and latched during COPY. A commit that
    // coincides with frame_gap in IDLE only arms PENDING, because frame_gap
    // has no meaning in IDLE. A commit on the last copy cycle still counts as
    // a re-commit.
    always_comb begin
        state_d    = state;
        start_copy = 1'b0;
        copy_last  = 1'b0;
        case (state)
            IDLE: begin
                if (commit) begin
                    state_d = PENDING;
                end
            end
            PENDING: begin
                if (frame_gap) begin
                    state_d    = COPY;
                    start_copy = 1'b1;
                end
            end
            COPY: begin
                if (idx == LAST_IDX) begin
                    copy_last = 1'b1;
                    state_d   = (recommit || commit) ? PENDING : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Copy bookkeeping. The re-commit flag is cleared on the last copy cycle,
    // after any commit in that same cycle has already been routed to PENDING
    // by the next-state logic.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx         <= '0;
            brt_q       <= '0;
            recommit    <= 1'b0;
            frame_count <= '0;
        end else begin
            if (start_copy) begin
                idx      <= '0;
                brt_q    <= brightness;
                recommit <= 1'b0;
            end
            if (state == COPY) begin
                idx <= copy_last ? '0 : idx + ADDR_W'(1);
                if (commit) begin
                    recommit <= 1'b1;
                end
                if (copy_last) begin
                    recommit    <= 1'b0;
                    frame_count <= frame_count + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                shadow[i] <= '0;
            end
        end else if (wr_accept) begin
            shadow[wr.wr_addr] <= wr.wr_data;
        end
    end

    // The shadow is never written during COPY, so shadow[idx] is stable for
    // the whole copy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                active[i] <= '0;
            end
        end else if (state == COPY) begin
            active[idx] <= scale_grb(shadow[idx], brt_q);
        end
    end

    // If a slot is wider than 24 bits, the colour word sits at the top of the
    // slot and the remaining low bits are zero.
    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_slot
        localparam int TOP = NUM_LEDS*BITS_PER_LED - 1 - BITS_PER_LED*i;
        if (BITS_PER_LED == 24) begin : g_exact
            assign bits[TOP -: 24] = active[i];
        end else begin : g_pad
            assign bits[TOP -: 24]                 = active[i];
            assign bits[TOP-24 -: BITS_PER_LED-24] = '0;
        end
    end
endmodule

// File: tb/tb_led_frame_controller.sv
module tb_led_frame_controller;
    localparam int N = 64;
    localparam int W = N * 24;

    logic         clk = 1'b0;
    logic         reset;
    logic [7:0]   brightness;
    logic         commit;
    logic         frame_gap;
    logic         busy;
    logic [W-1:0] bits;
    logic [15:0]  frame_count;

    led_frame_controller_if #(.NUM_LEDS(N)) wr_bus ();

    led_frame_controller #(.NUM_LEDS(N), .BITS_PER_LED(24)) dut (
        .clk         (clk),
        .reset       (reset),
        .wr          (wr_bus.slave),
        .brightness  (brightness),
        .commit      (commit),
        .frame_gap   (frame_gap),
        .busy        (busy),
        .bits        (bits),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [5:0]  addr;
        logic [23:0] data;
        logic [7:0]  brt;
        logic [23:0] exp_slot;
    } vec_t;

    vec_t vecs [7];

    function automatic logic [23:0] slotOf(input int i);
        return bits[W-1-24*i -: 24];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkBits(input string name, input logic [W-1:0] expected);
        int first;
        first = -1;
        for (int i = N - 1; i >= 0; i--) begin
            if (bits[W-1-24*i -: 24] !== expected[W-1-24*i -: 24]) first = i;
        end
        total++;
        if (first >= 0) begin
            bad++;
            $display("[TB] FAIL %s: LED %0d got 0x%06h, want 0x%06h", name, first,
                     bits[W-1-24*first -: 24], expected[W-1-24*first -: 24]);
        end
    endtask

    task automatic doReset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic writeLed(input logic [5:0] addr, input logic [23:0] data);
        @(negedge clk);
        wr_bus.wr_en   = 1'b1;
        wr_bus.wr_addr = addr;
        wr_bus.wr_data = data;
        @(negedge clk);
        wr_bus.wr_en   = 1'b0;
    endtask

    // Waits at negedges until busy drops, with a cycle budget.
    task automatic waitIdle(input string name);
        int guard;
        guard = 0;
        while (busy && guard < 20000) begin
            guard++;
            @(negedge clk);
        end
        if (busy) checkOutput({name, "_timeout"}, 32'(busy), 32'd0);
    endtask

    // commit, then frame_gap on the next cycle; busyCycles counts the negedges
    // seen with busy high, starting at the one where frame_gap is driven.
    task automatic publish(input logic [7:0] brt, output int busyCycles);
        int guard;
        @(negedge clk);
        brightness = brt;
        commit     = 1'b1;
        @(negedge clk);
        commit     = 1'b0;
        frame_gap  = 1'b1;
        busyCycles = busy ? 1 : 0;
        @(negedge clk);
        frame_gap  = 1'b0;
        guard = 0;
        while (busy && guard < 1000) begin
            busyCycles++;
            guard++;
            @(negedge clk);
        end
    endtask

    task automatic applyStimulus(input int k);
        int cyc;
        writeLed(vecs[k].addr, vecs[k].data);
        publish(vecs[k].brt, cyc);
        checkOutput($sformatf("vec%0d_busy_cycles", k), 32'(cyc), 32'd65);
        checkOutput($sformatf("vec%0d_slot", k), {8'h0, slotOf(int'(vecs[k].addr))}, {8'h0, vecs[k].exp_slot});
        checkOutput($sformatf("vec%0d_frame_count", k), {16'h0, frame_count}, 32'(k + 1));
    endtask

    initial begin
        logic [W-1:0] exp0;
        int cyc;

        vecs[0] = '{6'd0,  24'hFF0000, 8'd255, 24'hFF0000};
        vecs[1] = '{6'd5,  24'h804020, 8'd127, 24'h402010};
        vecs[2] = '{6'd63, 24'hFFFFFF, 8'd0,   24'h000000};
        vecs[3] = '{6'd10, 24'h123456, 8'd255, 24'h123456};
        vecs[4] = '{6'd20, 24'hFFFFFF, 8'd254, 24'hFEFEFE};
        vecs[5] = '{6'd31, 24'h10F0AA, 8'd128, 24'h087855};
        vecs[6] = '{6'd63, 24'h01FF80, 8'd63,  24'h003F20};

        reset          = 1'b1;
        brightness     = 8'd255;
        commit         = 1'b0;
        frame_gap      = 1'b0;
        wr_bus.wr_en   = 1'b0;
        wr_bus.wr_addr = '0;
        wr_bus.wr_data = '0;
        doReset();

        $display("[TB] reset state");
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_wr_ready", 32'(wr_bus.wr_ready), 32'd1);
        checkOutput("reset_frame_count", {16'h0, frame_count}, 32'd0);
        checkBits("reset_bits", '0);

        $display("[TB] frame_gap in IDLE");
        @(negedge clk);
        frame_gap = 1'b1;
        @(negedge clk);
        frame_gap = 1'b0;
        checkOutput("gap_idle_busy", 32'(busy), 32'd0);
        @(negedge clk);
        checkOutput("gap_idle_busy_later", 32'(busy), 32'd0);

        $display("[TB] vector table");
        for (int k = 0; k < 7; k++) begin
            applyStimulus(k);
            if (k == 0) begin
                exp0 = '0;
                exp0[W-1 -: 24] = 24'hFF0000;
                checkBits("vec0_full_frame", exp0);
            end
        end

        $display("[TB] write during COPY is dropped");
        writeLed(6'd7, 24'h111111);
        @(negedge clk);
        brightness = 8'd255;
        commit     = 1'b1;
        @(negedge clk);
        commit     = 1'b0;
        frame_gap  = 1'b1;
        @(negedge clk);
        frame_gap  = 1'b0;
        repeat (3) @(negedge clk);
        wr_bus.wr_en   = 1'b1;
        wr_bus.wr_addr = 6'd7;
        wr_bus.wr_data = 24'hEEEEEE;
        checkOutput("copy_wr_ready", 32'(wr_bus.wr_ready), 32'd0);
        @(negedge clk);
        wr_bus.wr_en = 1'b0;
        waitIdle("copy_write");
        checkOutput("copy_write_slot7_first", {8'h0, slotOf(7)}, 32'h111111);
        publish(8'd255, cyc);
        checkOutput("copy_write_slot7_second", {8'h0, slotOf(7)}, 32'h111111);
        checkOutput("copy_write_frame_count", {16'h0, frame_count}, 32'd9);

        $display("[TB] re-commit during COPY");
        doReset();
        writeLed(6'd3, 24'h0A0B0C);
        @(negedge clk);
        brightness = 8'd255;
        commit     = 1'b1;
        @(negedge clk);
        commit     = 1'b0;
        frame_gap  = 1'b1;
        @(negedge clk);
        frame_gap  = 1'b0;
        cyc = 0;
        while (busy && !wr_bus.wr_ready && cyc < 1000) begin
            commit    = (cyc == 10);
            frame_gap = (cyc == 20);
            cyc++;
            @(negedge clk);
        end
        commit    = 1'b0;
        frame_gap = 1'b0;
        checkOutput("recommit_copy_cycles", 32'(cyc), 32'd64);
        checkOutput("recommit_pending_busy", 32'(busy), 32'd1);
        checkOutput("recommit_frame_count1", {16'h0, frame_count}, 32'd1);
        repeat (5) @(negedge clk);
        checkOutput("recommit_still_pending", {30'h0, busy, wr_bus.wr_ready}, 32'd3);
        frame_gap = 1'b1;
        @(negedge clk);
        frame_gap = 1'b0;
        checkOutput("recommit_second_copy", 32'(wr_bus.wr_ready), 32'd0);
        waitIdle("recommit");
        checkOutput("recommit_frame_count2", {16'h0, frame_count}, 32'd2);
        checkOutput("recommit_slot3", {8'h0, slotOf(3)}, 32'h0A0B0C);

        $display("[TB] commit with frame_gap in IDLE, then long wait");
        doReset();
        writeLed(6'd2, 24'hABCDEF);
        @(negedge clk);
        brightness = 8'd255;
        commit     = 1'b1;
        frame_gap  = 1'b1;
        @(negedge clk);
        commit     = 1'b0;
        frame_gap  = 1'b0;
        checkOutput("coincide_pending", {30'h0, busy, wr_bus.wr_ready}, 32'd3);
        repeat (10000) @(negedge clk);
        checkOutput("long_wait_pending", {30'h0, busy, wr_bus.wr_ready}, 32'd3);
        checkOutput("long_wait_frame_count", {16'h0, frame_count}, 32'd0);
        checkBits("long_wait_bits", '0);
        frame_gap = 1'b1;
        @(negedge clk);
        frame_gap = 1'b0;
        waitIdle("long_wait");
        checkOutput("long_wait_slot2", {8'h0, slotOf(2)}, 32'hABCDEF);
        checkOutput("long_wait_frame_count_after", {16'h0, frame_count}, 32'd1);

        $display("[TB] reset mid-COPY");
        doReset();
        writeLed(6'd0, 24'h102030);
        writeLed(6'd63, 24'h405060);
        publish(8'd255, cyc);
        writeLed(6'd0, 24'hFFFFFF);
        writeLed(6'd63, 24'hFFFFFF);
        @(negedge clk);
        commit    = 1'b1;
        @(negedge clk);
        commit    = 1'b0;
        frame_gap = 1'b1;
        @(negedge clk);
        frame_gap = 1'b0;
        repeat (30) @(negedge clk);
        checkOutput("midcopy_slot0_new", {8'h0, slotOf(0)}, 32'hFFFFFF);
        checkOutput("midcopy_slot63_old", {8'h0, slotOf(63)}, 32'h405060);
        checkOutput("midcopy_busy", 32'(busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        checkBits("abort_bits", '0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_wr_ready", 32'(wr_bus.wr_ready), 32'd1);
        checkOutput("abort_frame_count", {16'h0, frame_count}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("after_abort_busy", 32'(busy), 32'd0);
        checkBits("after_abort_bits", '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
